// File: rtl/conv2d_engine_if.sv
// Control, operand and result signals of the 2-D convolution engine.
// The requester side drives start/operands; the engine drives results and status.
interface conv2d_engine_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int TILE   = 6,
  parameter int OUT_W  = 16
);
  localparam int OUT  = TILE - K + 1;
  localparam int RC_W = (OUT > 1) ? $clog2(OUT) : 1;

  logic                                     start;
  logic                                     signed_mode;
  logic                                     relu_en;
  logic [TILE-1:0][TILE-1:0][DATA_W-1:0]    input_tile;
  logic [K-1:0][K-1:0][DATA_W-1:0]          kernel;
  logic [OUT-1:0][OUT-1:0][OUT_W-1:0]       c;
  logic                                     out_valid;
  logic [RC_W-1:0]                          out_row;
  logic [RC_W-1:0]                          out_col;
  logic [OUT_W-1:0]                         out_data;
  logic                                     busy;
  logic                                     done;
  logic                                     sat_flag;

  modport master (
    output start, signed_mode, relu_en, input_tile, kernel,
    input  c, out_valid, out_row, out_col, out_data, busy, done, sat_flag
  );

  modport slave (
    input  start, signed_mode, relu_en, input_tile, kernel,
    output c, out_valid, out_row, out_col, out_data, busy, done, sat_flag
  );
endinterface

// File: rtl/conv2d_engine.sv
// Sequential K x K convolution over a TILE x TILE window, one MAC per cycle,
// with optional ReLU and saturation of each result to OUT_W bits.
module conv2d_engine #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int TILE   = 6,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K*K) + 1
) (
  input  logic           clk,
  input  logic           rst,
  conv2d_engine_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for start, operands not yet captured
  // MAC   | one product accumulated per cycle, n inner, m outer
  // WRITE | result for (row, col) finalised, stored and streamed
  // DONE  | run complete, done pulse follows
  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  localparam int OUT  = TILE - K + 1;
  localparam int RC_W = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int M_W  = (K > 1) ? $clog2(K) : 1;
  localparam int T_W  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int P_W  = 2*DATA_W;

  localparam logic [M_W-1:0]  K_LAST   = M_W'(K - 1);
  localparam logic [RC_W-1:0] OUT_LAST = RC_W'(OUT - 1);

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_t                                state;
  logic [TILE-1:0][TILE-1:0][DATA_W-1:0] tile_q;
  logic [K-1:0][K-1:0][DATA_W-1:0]       kern_q;
  logic                                  signed_q;
  logic                                  relu_q;
  logic [RC_W-1:0]                       row, col;
  logic [M_W-1:0]                        m, n;
  logic signed [ACC_W-1:0]               acc;

  logic [T_W-1:0]          ti, tj;
  logic [DATA_W-1:0]       pix, kw;
  logic signed [P_W-1:0]   prod_s;
  logic [P_W-1:0]          prod_u;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] relu_v;
  logic [OUT_W-1:0]        res;
  logic                    sat;

  always_comb begin
    ti       = T_W'(row) + T_W'(m);
    tj       = T_W'(col) + T_W'(n);
    pix      = tile_q[ti][tj];
    kw       = kern_q[m][n];
    prod_s   = $signed(pix) * $signed(kw);
    prod_u   = pix * kw;
    prod_ext = signed_q ? {{(ACC_W-P_W){prod_s[P_W-1]}}, prod_s}
                        : {{(ACC_W-P_W){1'b0}}, prod_u};
  end

  // ReLU is applied before the clamp, so a clamped negative never reaches saturation logic
  always_comb begin
    relu_v = (relu_q && acc[ACC_W-1]) ? '0 : acc;
    res    = relu_v[OUT_W-1:0];
    sat    = 1'b0;
    if (signed_q) begin
      if (relu_v > SMAX) begin
        res = SMAX[OUT_W-1:0];
        sat = 1'b1;
      end else if (relu_v < SMIN) begin
        res = SMIN[OUT_W-1:0];
        sat = 1'b1;
      end
    end else begin
      if (relu_v[ACC_W-1]) begin
        res = '0;
        sat = 1'b1;
      end else if (relu_v > UMAX) begin
        res = UMAX[OUT_W-1:0];
        sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tile_q       <= '0;
      kern_q       <= '0;
      signed_q     <= 1'b0;
      relu_q       <= 1'b0;
      row          <= '0;
      col          <= '0;
      m            <= '0;
      n            <= '0;
      acc          <= '0;
      bus.c        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_row  <= '0;
      bus.out_col  <= '0;
      bus.out_data <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sat_flag <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tile_q       <= bus.input_tile;
            kern_q       <= bus.kernel;
            signed_q     <= bus.signed_mode;
            relu_q       <= bus.relu_en;
            bus.sat_flag <= 1'b0;
            acc          <= '0;
            row          <= '0;
            col          <= '0;
            m            <= '0;
            n            <= '0;
            bus.busy     <= 1'b1;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (n == K_LAST) begin
            n <= '0;
            if (m == K_LAST) begin
              m     <= '0;
              state <= WRITE;
            end else begin
              m <= m + 1'b1;
            end
          end else begin
            n <= n + 1'b1;
          end
        end
        WRITE: begin
          bus.c[row][col] <= res;
          bus.out_data    <= res;
          bus.out_row     <= row;
          bus.out_col     <= col;
          bus.out_valid   <= 1'b1;
          if (sat) bus.sat_flag <= 1'b1;
          acc   <= '0;
          state <= MAC;
          if (col == OUT_LAST) begin
            col <= '0;
            if (row == OUT_LAST) begin
              row   <= '0;
              state <= DONE;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv2d_engine.sv
// Scoreboard bench for conv2d_engine: a reference model queues expected results
// at start; the stream monitor pops and compares them as out_valid fires.
module tb_conv2d_engine;
  localparam int DATA_W = 8;
  localparam int K      = 3;
  localparam int TILE   = 6;
  localparam int OUT_W  = 16;
  localparam int OUT    = TILE - K + 1;
  localparam int LAT    = OUT*OUT*(K*K+1) + 1;

  typedef struct {
    int          row;
    int          col;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv2d_engine_if #(.DATA_W(DATA_W), .K(K), .TILE(TILE), .OUT_W(OUT_W)) bus ();

  conv2d_engine #(.DATA_W(DATA_W), .K(K), .TILE(TILE), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  tile_s [TILE][TILE];
  logic [7:0]  kern_s [K][K];
  logic [15:0] exp_c  [OUT][OUT];
  bit          exp_sat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_row",  bus.out_row,  mon_e.row);
        chk("out_col",  bus.out_col,  mon_e.col);
        chk("out_data", bus.out_data, mon_e.data);
      end
    end
  end

  task automatic load(input int mode);
    for (int r = 0; r < TILE; r++)
      for (int q = 0; q < TILE; q++) begin
        case (mode)
          0: tile_s[r][q] = 8'd1;
          1, 2: tile_s[r][q] = 8'hFF;
          default: tile_s[r][q] = 8'($urandom);
        endcase
        bus.input_tile[r][q] = tile_s[r][q];
      end
    for (int r = 0; r < K; r++)
      for (int q = 0; q < K; q++) begin
        case (mode)
          0, 1: kern_s[r][q] = 8'd1;
          2: kern_s[r][q] = 8'hFF;
          default: kern_s[r][q] = 8'($urandom);
        endcase
        bus.kernel[r][q] = kern_s[r][q];
      end
  endtask

  task automatic model(input bit sm, input bit re);
    longint s, a, b, v;
    exp_t e;
    exp_sat = 1'b0;
    for (int r = 0; r < OUT; r++)
      for (int q = 0; q < OUT; q++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++) begin
            a = sm ? longint'($signed(tile_s[r+i][q+j])) : longint'(tile_s[r+i][q+j]);
            b = sm ? longint'($signed(kern_s[i][j]))     : longint'(kern_s[i][j]);
            s += a * b;
          end
        if (re && s < 0) s = 0;
        v = s;
        if (sm) begin
          if (s > 32767)       begin v = 32767;  exp_sat = 1'b1; end
          else if (s < -32768) begin v = -32768; exp_sat = 1'b1; end
        end else begin
          if (s < 0)           begin v = 0;      exp_sat = 1'b1; end
          else if (s > 65535)  begin v = 65535;  exp_sat = 1'b1; end
        end
        exp_c[r][q] = v[15:0];
        e.row  = r;
        e.col  = q;
        e.data = v[15:0];
        sb.push_back(e);
      end
  endtask

  task automatic run(input bit sm, input bit re, input bit disturb, input int abort_at);
    int cyc;
    int nd;
    bus.signed_mode = sm;
    bus.relu_en     = re;
    model(sm, re);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 5) chk("busy_in_run", bus.busy, 1);
      if (disturb) begin
        bus.start = (cyc == 10 || cyc == 160);
        if (cyc == 20 || cyc == 90) bus.signed_mode = ~bus.signed_mode;
        if (cyc == 30) begin
          bus.relu_en    = ~re;
          bus.input_tile = {TILE*TILE{8'($urandom)}};
          bus.kernel     = {K*K{8'($urandom)}};
        end
      end
      if (abort_at != 0 && cyc == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("abort_busy",      bus.busy,      0);
        chk("abort_valid",     bus.out_valid, 0);
        chk("abort_done",      bus.done,      0);
        chk("abort_sat",       bus.sat_flag,  0);
        chk("abort_out_data",  bus.out_data,  0);
        chk("abort_c_cleared", longint'(|bus.c), 0);
        sb.delete();
        nd = 0;
        repeat (3) begin
          @(negedge clk);
          if (bus.done) nd++;
        end
        rst = 1'b0;
        repeat (200) begin
          @(negedge clk);
          if (bus.done) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_idle", bus.busy, 0);
        return;
      end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk("latency", cyc, LAT);
    chk("sat_flag", bus.sat_flag, exp_sat);
    for (int r = 0; r < OUT; r++)
      for (int q = 0; q < OUT; q++)
        chk($sformatf("c[%0d][%0d]", r, q), bus.c[r][q], exp_c[r][q]);
    chk("scoreboard_drained", sb.size(), 0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("extra_done", nd, 0);
    chk("idle_after_run", bus.busy, 0);
    chk("sat_flag_held", bus.sat_flag, exp_sat);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.relu_en     = 1'b0;
    bus.input_tile  = '0;
    bus.kernel      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_done",  bus.done,      0);
    chk("rst_c",     longint'(|bus.c), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load(0); run(1'b0, 1'b0, 1'b0, 0);   // all ones -> 9
    load(1); run(1'b1, 1'b0, 1'b0, 0);   // -1 * 1 -> -9
    load(1); run(1'b1, 1'b1, 1'b0, 0);   // ReLU -> 0
    load(2); run(1'b0, 1'b0, 1'b0, 0);   // unsigned clamp to 65535
    load(2); run(1'b1, 1'b0, 1'b0, 0);   // signed -> 9
    load(3); run(1'b1, 1'b0, 1'b1, 0);   // mid-run start / mode / operand changes ignored
    load(3); run(1'b0, 1'b1, 1'b1, 0);
    load(3); run(1'b1, 1'b1, 1'b0, 50);  // abort
    load(3); run(1'b1, 1'b0, 1'b0, 0);   // fresh run after abort

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv2d_engine.md
CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the pixel and kernel element width.
REQ-002 SHALL have parameter K, default 3, the kernel edge (K x K).
REQ-003 SHALL have parameter TILE, default 6, the input tile edge; derived OUT = TILE-K+1, with default 4.
REQ-004 SHALL have parameter OUT_W, default 16, the result width.
REQ-005 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(K*K)+1, the accumulator width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: run request.
REQ-009 SHALL have port signed_mode, input, 1 bit: 1 = operands are two's complement, 0 = unsigned.
REQ-010 SHALL have port relu_en, input, 1 bit: clamp negative results to 0.
REQ-011 SHALL have port input_tile, input, [TILE][TILE] x DATA_W: the input window.
REQ-012 SHALL have port kernel, input, [K][K] x DATA_W: the weights.
REQ-013 SHALL have port c, output, [OUT][OUT] x OUT_W: the result matrix.
REQ-014 SHALL have the per-result stream ports:
- out_valid, output, 1 bit
- out_row, output, $clog2(OUT) bits
- out_col, output, $clog2(OUT) bits
- out_data, output, OUT_W bits
REQ-015 SHALL have port busy, output, 1 bit, high in every non-IDLE state.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 SHALL have port sat_flag, output, 1 bit: sticky per run, set when any result of the run saturated.

Function
REQ-018 SHALL implement the FSM states IDLE, MAC, WRITE, DONE.
REQ-019 SHALL accept start only in IDLE. On acceptance it SHALL:
- snapshot input_tile, kernel, signed_mode and relu_en into internal registers;
- clear sat_flag and the accumulator;
- set row = col = m = n = 0;
- go to MAC.
REQ-020 SHALL ignore start in MAC, WRITE and DONE, and SHALL ignore changes to any input port other than rst outside the acceptance cycle.
REQ-021 In MAC, each cycle SHALL add the product tile[row+m][col+n] * kern[m][n] to the accumulator.
- The product SHALL be sign- or zero-extended to ACC_W according to the latched mode.
- n SHALL step first, then m.
- After exactly K*K MAC cycles the FSM SHALL go to WRITE.
REQ-022 In WRITE (one cycle), the final value SHALL be formed as: ReLU (if latched relu_en and the accumulator is negative, result = 0), then saturation to OUT_W. The final value SHALL be:
- written to c[row][col];
- presented on out_data with out_row=row, out_col=col, out_valid=1 for that cycle only.
REQ-023 Saturation range SHALL be [-2^(OUT_W-1), 2^(OUT_W-1)-1] in signed mode and [0, 2^OUT_W-1] in unsigned mode. Any clamp SHALL set sat_flag.
REQ-024 After WRITE, col SHALL increment. At col=OUT-1, col SHALL wrap to 0 and row SHALL increment. m, n and the accumulator SHALL clear, and the FSM SHALL return to MAC. After WRITE of (OUT-1, OUT-1), the FSM SHALL go to DONE.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE. A start in the DONE cycle SHALL be ignored.
REQ-026 Latency from the start-acceptance edge to done=1 SHALL be exactly OUT*OUT*(K*K+1)+1 cycles. The default parameters give 161.
REQ-027 Each entry of c SHALL hold its value until overwritten by a later WRITE or cleared by reset. c SHALL NOT be cleared at start.
REQ-028 sat_flag SHALL remain valid after done until the next accepted start.
REQ-029 Multiplication SHALL be inferred and SHALL NOT instantiate a vendor primitive. The accumulator SHALL never overflow for the derived ACC_W.

Reset
REQ-030 rst high SHALL asynchronously force:
- state=IDLE;
- all counters, the accumulator and the snapshot registers = 0;
- c all 0, out_data=0, out_row=out_col=0;
- out_valid=0, busy=0, done=0, sat_flag=0.
REQ-031 rst asserted mid-run SHALL abort the run with no done pulse. Operation SHALL resume only on a new start after rst is deasserted.

Verification
REQ-032 Reset: assert rst mid-cycle -> all outputs 0 immediately, busy=0.
REQ-033 Unsigned, all tile=1, all kernel=1, defaults -> 16 out_valid pulses in row-major order, every out_data=9, c all 9, done at cycle 161, sat_flag=0.
REQ-034 Signed, tile=-1 (0xFF), kernel=1:
- relu_en=0 -> every result = -9 (0xFFF7);
- relu_en=1 -> every result = 0, sat_flag=0.
REQ-035 Unsigned, tile=255, kernel=255 -> each sum 585225 clamps to 65535, sat_flag=1 after done; in signed mode the same bit pattern gives (-1)*(-1)*9 = 9.
REQ-036 start pulsed at cycles 10 and 160 of a run, and signed_mode toggled mid-run -> ignored; results match the snapshot; exactly one done.
REQ-037 rst asserted at cycle 50 of a run, then start reissued -> no done for the aborted run; the new run completes in 161 cycles with correct c.
